// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, legal
// oversampling ratios, default word width and the majority-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter plus 3-sample majority vote around the bit centre.
// bit_val/sample_done are registered at edge_cnt = Prescale/2+1, so the
// strobe is seen by the FSM one cycle later, well before the bit wraps.
module uart_rx_sampler import uart_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    input  logic       run,
    input  logic       clear,
    output logic       edge_wrap,
    output logic       bit_val,
    output logic       sample_done
);

    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic       s0;
    logic       s1;

    assign half      = prescale >> 1;
    assign edge_wrap = run && (edge_cnt == prescale - 6'd1);

    // Edge counter: holds at 0 while idle, wraps every Prescale cycles.
    always_ff @(posedge clk) begin
        if (rst)
            edge_cnt <= '0;
        else if (clear)
            edge_cnt <= '0;
        else if (run)
            edge_cnt <= edge_wrap ? 6'd0 : edge_cnt + 6'd1;
    end

    // Capture three centre samples and register their majority with a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            bit_val     <= 1'b0;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (run && !clear) begin
                if (edge_cnt == half - 6'd1)
                    s0 <= rx_in;
                if (edge_cnt == half)
                    s1 <= rx_in;
                if (edge_cnt == half + 6'd1) begin
                    bit_val     <= majority3(s0, s1, rx_in);
                    sample_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing, LSB-first deserializer,
// parity and stop checks, one-cycle result pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | line idle; first low cycle counts as start edge 0
//   ST_START  | confirming start bit; voted 1 means glitch, abort
//   ST_DATA   | shifting in DATA_WIDTH voted bits, LSB first
//   ST_PARITY | checking parity bit against the received word
//   ST_STOP   | checking stop bit; results issued at its last edge
module uart_rx import uart_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    rx_state_e             state;
    rx_state_e             state_nxt;
    logic                  run;
    logic                  abort;
    logic                  shift_en;
    logic                  par_check;
    logic                  stop_check;
    logic                  frame_end;
    logic                  edge_wrap;
    logic                  bit_val;
    logic                  sample_done;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BCW-1:0]        bit_cnt;
    logic                  par_err_q;
    logic                  stop_err_q;

    uart_rx_sampler u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .rx_in       (RX_IN),
        .prescale    (Prescale),
        .run         (run),
        .clear       (abort),
        .edge_wrap   (edge_wrap),
        .bit_val     (bit_val),
        .sample_done (sample_done)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode: transitions happen on the bit wrap, except the
    // glitch abort which leaves START as soon as the vote is known.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
            ST_START: begin
                if (sample_done && bit_val) state_nxt = ST_IDLE;
                else if (edge_wrap)         state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (edge_wrap && (bit_cnt == BCW'(DATA_WIDTH - 1)))
                    state_nxt = parity_enable ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (edge_wrap) state_nxt = ST_STOP;
            ST_STOP:   if (edge_wrap) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the sampler and datapath.
    always_comb begin
        run        = (state != ST_IDLE) || !RX_IN;
        abort      = (state == ST_START)  && sample_done && bit_val;
        shift_en   = (state == ST_DATA)   && sample_done;
        par_check  = (state == ST_PARITY) && sample_done;
        stop_check = (state == ST_STOP)   && sample_done;
        frame_end  = (state == ST_STOP)   && edge_wrap;
    end

    // Deserializer, data-bit counter and error latches (cleared while idle).
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                bit_cnt    <= '0;
                par_err_q  <= 1'b0;
                stop_err_q <= 1'b0;
            end
            if (shift_en)
                shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            if ((state == ST_DATA) && edge_wrap)
                bit_cnt <= bit_cnt + BCW'(1);
            if (par_check && (bit_val != ((^shift_reg) ^ parity_type)))
                par_err_q <= 1'b1;
            if (stop_check && !bit_val)
                stop_err_q <= 1'b1;
        end
    end

    // Result pulses, issued in the cycle IDLE is re-entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            if (frame_end) begin
                if (!par_err_q && !stop_err_q) begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shift_reg;
                end else begin
                    parity_error <= par_err_q;
                    stop_error   <= stop_err_q;
                end
            end
        end
    end

endmodule
